// File: rtl/boreal_ledger.sv
// boreal_ledger
//   Append-only, hash-chained event ledger. Every led_wr pulse gets the next
//   sequence number and is folded into a running 32-bit chain digest, then
//   buffered in a first-word-fall-through ring for a downstream sink.
//   Events arriving while the ring is full still advance seq/digest (so the
//   sink sees a sequence gap) and are counted as drops.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   led_wr, led_event   : append strobe and 256-bit payload
//   out_valid/out_ready : head handshake (ring not empty / sink accepts)
//   out_data/seq/digest : head entry fields, zero while empty
//   full                : ring holds DEPTH entries
//   mmio_we/addr/wdata  : register write port (0x04 clear ovf, 0x05 flush)
//   mmio_rdata          : registered read data (0x00..0x04)
module boreal_ledger #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         led_wr,
    input  logic [255:0] led_event,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic [31:0]  out_seq,
    output logic [31:0]  out_digest,
    output logic         full,
    input  logic         mmio_we,
    input  logic [7:0]   mmio_addr,
    input  logic [31:0]  mmio_wdata,
    output logic [31:0]  mmio_rdata
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   r_seq;
    logic [31:0]   r_digest;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_drop_ctr;
    logic          r_ovf;
    logic [31:0]   r_mmio_rdata;
    // Entry layout: {event[255:0], seq[31:0], digest[31:0]}
    logic [319:0]  r_mem [DEPTH];

    logic [31:0]   w_fold;
    logic [31:0]   w_digest_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_accept;
    logic          w_drop;
    logic          w_flush;
    logic          w_clr_ovf;
    logic [319:0]  w_head;
    logic          w_unused;

    // fold(e): XOR of the eight 32-bit words of the payload
    always_comb begin
        w_fold = '0;
        for (int i = 0; i < 8; i++) begin
            w_fold = w_fold ^ led_event[i*32 +: 32];
        end
    end

    assign w_digest_nxt = {r_digest[26:0], r_digest[31:27]} ^ w_fold ^ r_seq;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == L_DEPTH);
    assign w_pop     = !w_empty && out_ready;
    // A pop in the same cycle frees a slot, so a full ring still accepts.
    assign w_accept  = led_wr && (!w_full || w_pop);
    assign w_drop    = led_wr && !w_accept;
    assign w_flush   = mmio_we && (mmio_addr == 8'h05) && mmio_wdata[0];
    assign w_clr_ovf = mmio_we && (mmio_addr == 8'h04) && mmio_wdata[0];
    assign w_unused  = ^mmio_wdata[31:1];

    // Flush behaves like reset for ledger state (it wins over append/pop),
    // but leaves the read-data register alone.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_seq      <= '0;
            r_digest   <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_ctr <= '0;
            r_ovf      <= 1'b0;
        end else begin
            // Dropped events are still sequenced and digested.
            if (led_wr) begin
                r_seq    <= r_seq + 32'd1;
                r_digest <= w_digest_nxt;
            end
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_drop && (r_drop_ctr != 32'hFFFF_FFFF)) begin
                r_drop_ctr <= r_drop_ctr + 32'd1;
            end
            // A new drop overrides a clear in the same cycle.
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_clr_ovf) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !w_flush && w_accept) begin
            r_mem[r_wr_ptr] <= {led_event, r_seq, w_digest_nxt};
        end
    end

    // Read data shows state from before the sampling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mmio_rdata <= '0;
        end else begin
            case (mmio_addr)
                8'h00:   r_mmio_rdata <= r_seq;
                8'h01:   r_mmio_rdata <= r_digest;
                8'h02:   r_mmio_rdata <= 32'(r_count);
                8'h03:   r_mmio_rdata <= r_drop_ctr;
                8'h04:   r_mmio_rdata <= {29'b0, w_empty, w_full, r_ovf};
                default: r_mmio_rdata <= '0;
            endcase
        end
    end

    // Head is masked while empty so stale ring contents never leak out.
    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : w_head[319:64];
    assign out_seq    = w_empty ? '0 : w_head[63:32];
    assign out_digest = w_empty ? '0 : w_head[31:0];
    assign full       = w_full;
    assign mmio_rdata = r_mmio_rdata;

endmodule

// File: tb/tb_boreal_ledger.sv
module tb_boreal_ledger;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [31:0]  g;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         led_wr     [2];
    logic [255:0] led_event  [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [255:0] out_data   [2];
    logic [31:0]  out_seq    [2];
    logic [31:0]  out_digest [2];
    logic         full       [2];
    logic         mmio_we    [2];
    logic [7:0]   mmio_addr  [2];
    logic [31:0]  mmio_wdata [2];
    logic [31:0]  mmio_rdata [2];

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t sb [2][$];
    logic [31:0] m_seq [2];
    logic [31:0] m_dig [2];
    logic stab_en = 1'b0;
    logic stall [2];
    ent_t held  [2];
    ent_t e_m;

    always #5 clk = ~clk;

    boreal_ledger #(.DEPTH(4)) u_l4 (
        .clk(clk), .rst(rst), .led_wr(led_wr[0]), .led_event(led_event[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_seq(out_seq[0]), .out_digest(out_digest[0]), .full(full[0]),
        .mmio_we(mmio_we[0]), .mmio_addr(mmio_addr[0]), .mmio_wdata(mmio_wdata[0]),
        .mmio_rdata(mmio_rdata[0]));

    boreal_ledger #(.DEPTH(16)) u_l16 (
        .clk(clk), .rst(rst), .led_wr(led_wr[1]), .led_event(led_event[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_seq(out_seq[1]), .out_digest(out_digest[1]), .full(full[1]),
        .mmio_we(mmio_we[1]), .mmio_addr(mmio_addr[1]), .mmio_wdata(mmio_wdata[1]),
        .mmio_rdata(mmio_rdata[1]));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [255:0] e);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r ^= e[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] mk_ev(input int i);
        logic [255:0] e;
        for (int w = 0; w < 8; w++) e[w*32 +: 32] = 32'(i) * 32'h0101_0101 + 32'(w * 7 + 3);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an append for the coming edge and update the reference model.
    task automatic append(input int k, input logic [255:0] ev, input bit acc);
        logic [31:0] d;
        d = {m_dig[k][26:0], m_dig[k][31:27]} ^ fold(ev) ^ m_seq[k];
        if (acc) sb[k].push_back('{ev, m_seq[k], d});
        m_seq[k] = m_seq[k] + 32'd1;
        m_dig[k] = d;
        led_wr[k] = 1'b1;
        led_event[k] = ev;
    endtask

    task automatic push(input int k, input logic [255:0] ev, input bit acc);
        append(k, ev, acc);
        tick();
        led_wr[k] = 1'b0;
    endtask

    task automatic mmio_wr(input int k, input logic [7:0] a, input logic [31:0] d);
        mmio_we[k] = 1'b1; mmio_addr[k] = a; mmio_wdata[k] = d;
        tick();
        mmio_we[k] = 1'b0;
    endtask

    task automatic mmio_rd(input int k, input logic [7:0] a, input logic [31:0] exp, input string nm);
        mmio_addr[k] = a;
        tick();
        chk(nm, mmio_rdata[k], exp);
    endtask

    task automatic flush(input int k);
        mmio_wr(k, 8'h05, 32'h1);
        m_seq[k] = '0; m_dig[k] = '0;
        sb[k].delete();
    endtask

    task automatic drain(input int k);
        int n = 0;
        out_ready[k] = 1'b1;
        while (out_valid[k] && n < 200) begin
            tick();
            n++;
        end
        out_ready[k] = 1'b0;
        chk($sformatf("drain%0d_empty", k), out_valid[k], 1'b0);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks head stability.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (stab_en && stall[k]) begin
                    chk($sformatf("stable%0d", k),
                        {out_valid[k], out_data[k], out_seq[k], out_digest[k]},
                        {1'b1, held[k]});
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("mon%0d_unexpected_seq", k), out_seq[k], 32'hDEAD_BEEF);
                    end else begin
                        e_m = sb[k].pop_front();
                        chk($sformatf("mon%0d_data", k), out_data[k], e_m.d);
                        chk($sformatf("mon%0d_seq", k), out_seq[k], e_m.s);
                        chk($sformatf("mon%0d_digest", k), out_digest[k], e_m.g);
                    end
                end
                stall[k] = out_valid[k] && !out_ready[k];
                held[k]  = {out_data[k], out_seq[k], out_digest[k]};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            led_wr[k] = 0; led_event[k] = '0; out_ready[k] = 0;
            mmio_we[k] = 0; mmio_addr[k] = '0; mmio_wdata[k] = '0;
            m_seq[k] = '0; m_dig[k] = '0; stall[k] = 0; held[k] = '0;
        end
        repeat (3) tick();
        chk("rst_valid", out_valid[0], 1'b0);
        chk("rst_full", full[0], 1'b0);
        chk("rst_rdata", mmio_rdata[0], 32'h0);
        chk("rst_data", out_data[0], 256'h0);
        chk("rst_seq", out_seq[0], 32'h0);
        chk("rst_digest", out_digest[0], 32'h0);
        chk("rst_valid16", out_valid[1], 1'b0);
        rst = 1'b0;
        tick();

        // Digest reference: two events with word0 = 1
        push(0, 256'h1, 1);
        push(0, 256'h1, 1);
        chk("ref_valid", out_valid[0], 1'b1);
        chk("ref_seq0", out_seq[0], 32'h0);
        chk("ref_dig0", out_digest[0], 32'h0000_0001);
        mmio_rd(0, 8'h00, 32'd2, "ref_seqreg");
        mmio_rd(0, 8'h01, 32'h0000_0020, "ref_digreg");
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("ref_seq1", out_seq[0], 32'h1);
        chk("ref_dig1", out_digest[0], 32'h0000_0020);
        drain(0);

        // Overflow: 5 events into 4 entries with the sink stalled
        flush(0);
        for (int i = 0; i < 5; i++) push(0, mk_ev(i), i < 4);
        chk("ovf_full", full[0], 1'b1);
        mmio_rd(0, 8'h02, 32'd4, "ovf_count");
        mmio_rd(0, 8'h03, 32'd1, "ovf_drop");
        mmio_rd(0, 8'h04, 32'h3, "ovf_status");
        drain(0);
        push(0, mk_ev(9), 1);
        chk("ovf_gap_seq", out_seq[0], 32'd5);
        drain(0);

        // Full ring with simultaneous push and pop
        flush(0);
        for (int i = 0; i < 4; i++) push(0, mk_ev(20 + i), 1);
        out_ready[0] = 1'b1;
        push(0, mk_ev(30), 1);
        out_ready[0] = 1'b0;
        chk("pp_full", full[0], 1'b1);
        mmio_rd(0, 8'h02, 32'd4, "pp_count");
        mmio_rd(0, 8'h03, 32'd0, "pp_drop");
        drain(0);

        // Flush in the same cycle as an append (after a drop)
        flush(0);
        for (int i = 0; i < 5; i++) push(0, mk_ev(40 + i), i < 4);
        led_wr[0] = 1'b1; led_event[0] = mk_ev(50);
        mmio_we[0] = 1'b1; mmio_addr[0] = 8'h05; mmio_wdata[0] = 32'h1;
        tick();
        led_wr[0] = 1'b0; mmio_we[0] = 1'b0;
        m_seq[0] = '0; m_dig[0] = '0; sb[0].delete();
        chk("fl_valid", out_valid[0], 1'b0);
        mmio_rd(0, 8'h00, 32'd0, "fl_seq");
        mmio_rd(0, 8'h01, 32'd0, "fl_digest");
        mmio_rd(0, 8'h03, 32'd0, "fl_drop");
        mmio_rd(0, 8'h04, 32'h4, "fl_status");

        // Sequence wrap
        flush(0);
        force u_l4.r_seq = 32'hFFFF_FFFF;
        #1;
        release u_l4.r_seq;
        m_seq[0] = 32'hFFFF_FFFF;
        push(0, mk_ev(60), 1);
        push(0, mk_ev(61), 1);
        chk("wrap_seq0", out_seq[0], 32'hFFFF_FFFF);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("wrap_seq1", out_seq[0], 32'h0);
        drain(0);
        mmio_rd(0, 8'h00, 32'd1, "wrap_seqreg");

        // Clearing ovf in the same cycle as a drop keeps it set
        flush(0);
        for (int i = 0; i < 4; i++) push(0, mk_ev(70 + i), 1);
        append(0, mk_ev(80), 0);
        mmio_we[0] = 1'b1; mmio_addr[0] = 8'h04; mmio_wdata[0] = 32'h1;
        tick();
        led_wr[0] = 1'b0; mmio_we[0] = 1'b0;
        mmio_rd(0, 8'h04, 32'h3, "sticky_status");
        mmio_wr(0, 8'h04, 32'h1);
        mmio_rd(0, 8'h04, 32'h2, "clr_status");
        mmio_rd(0, 8'h03, 32'd1, "sticky_drop");
        drain(0);

        // Backpressure on the DEPTH=16 instance
        stab_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            out_ready[1] = ($urandom_range(0, 3) != 0);
            push(1, mk_ev(100 + i), 1);
            out_ready[1] = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(1);
        stab_en = 1'b0;
        chk("bp_left", 32'(sb[1].size()), 32'd0);
        mmio_rd(1, 8'h03, 32'd0, "bp_drop");
        mmio_rd(1, 8'h00, 32'd100, "bp_seq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/boreal_ledger.md
# boreal_ledger

Append-only, hash-chained event ledger directly downstream of the Phase-A gate. Every `led_wr`/`led_event` pulse from the gate is assigned a sequence number and folded into a running 32-bit chain digest. The event is then buffered in a first-word-fall-through ring for an external sink such as a DMA or host drain. Events that arrive while the buffer is full are still sequenced and digested, so a consumer always detects loss as a sequence gap; they are also counted as drops.

## Interface
Parameters:
- `DEPTH`, 16: ring entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: pointer width.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `led_wr` in 1: append strobe from the gate; one event per cycle.
- `led_event` in 256: event payload.
- `out_valid` out 1: head entry present (ring not empty).
- `out_ready` in 1: sink accepts head.
- `out_data` out 256: head event.
- `out_seq` out 32: sequence number of the head event.
- `out_digest` out 32: chain digest after folding the head event.
- `full` out 1: count == DEPTH.
- `mmio_we` in 1: register write.
- `mmio_addr` in 8: register index.
- `mmio_wdata` in 32: write data.
- `mmio_rdata` out 32: registered read data.

## Operation
- State:
  - `seq` (32): next sequence number.
  - `digest` (32).
  - `count` (AW+1), with `wr_ptr` and `rd_ptr` (AW).
  - `drop_ctr` (32).
  - `ovf` (sticky).
  - Ring entries are 320 bits: {event, seq, digest}.
- `fold(e)` = XOR of the eight 32-bit words of `e`.
- Append on `led_wr`:
  - Compute `d' = rotl(digest,5) ^ fold(led_event) ^ seq`.
  - `digest <= d'`.
  - `seq <= seq+1`; wraps 0xFFFFFFFF→0.
- Accept rule: the append is accepted if `count < DEPTH` or a pop occurs in the same cycle. An accepted append writes {led_event, seq, d'} at `wr_ptr`.
- Drop rule: if not accepted, no entry is written, `drop_ctr` increments (saturating at 0xFFFFFFFF), and `ovf <= 1`. `seq` and `digest` still advance.
- Pop: when `out_valid && out_ready`, `rd_ptr` advances. Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap modulo DEPTH.
- MMIO write map (others ignored):
  - 0x04: bit0=1 clears `ovf`.
  - 0x05: bit0=1 flush. Empties the ring and zeroes `seq`, `digest`, `drop_ctr` and `ovf`.
- MMIO read map (others read 0):
  - 0x00 `seq`.
  - 0x01 `digest`.
  - 0x02 `count`, zero-extended.
  - 0x03 `drop_ctr`.
  - 0x04 status {29'b0, empty, full, ovf}.
- Flush in the same cycle as `led_wr`: flush wins. The event is discarded, and neither sequenced, digested nor counted as a drop.
- Flush in the same cycle as a pop: flush wins. The pop is harmless.
- Clearing `ovf` in the same cycle as a new drop: the drop wins, so `ovf` = 1.

## Timing
- Reset values:
  - Internal state: `seq`, `digest`, `count`, pointers, `drop_ctr` all 0; `ovf` 0.
  - Outputs: `out_valid`=0, `full`=0, `mmio_rdata`=0. `out_data`, `out_seq` and `out_digest` read 0 while empty.
- Reset mid-operation clears everything at the next edge; ring contents become unobservable.
- Latency: `led_wr` sampled at edge N into an empty ring gives `out_valid`=1 with that entry from edge N onward (one cycle after the strobe is presented).
- Register reads: `seq`/`digest` reflect the append at the read register one cycle later.
- Throughput: one append and one pop per cycle, sustained.
- `out_*` are stable while `out_valid && !out_ready`.
- `mmio_rdata` is registered: the address sampled at edge N appears after edge N and shows state as of before edge N.
- MMIO write effects are visible at edge N+1.

## Test plan
- Digest reference: after reset, two events with word0=1 and other words 0.
  - Entry 0: `out_seq`=0, `out_digest`=0x00000001.
  - Entry 1: `out_seq`=1, `out_digest`=0x00000020.
  - MMIO 0x00 reads 2.
- Overflow (DEPTH=4): hold `out_ready`=0 and push 5 events.
  - `full`=1, `count`=4, `drop_ctr`=1, status=0x3.
  - Draining yields seq 0..3.
  - The next append shows `out_seq`=5.
- Full with simultaneous push and pop (DEPTH=4): ring full, `led_wr` and `out_ready` in the same cycle.
  - Push accepted, `count` stays 4, `drop_ctr` stays 0.
- Flush vs append: 0x05 write=1 in the same cycle as `led_wr`.
  - Next cycle `out_valid`=0, `seq`=0, `digest`=0, `drop_ctr`=0.
- Backpressure: random `out_ready` over 100 events.
  - Output order and payloads match the input, `out_*` are stable while stalled, no drops at DEPTH=16 with ≥50% ready.
- Seq wrap and sticky clear:
  - Preload `seq` to 0xFFFFFFFF (hierarchical force) and append two events: they show seq 0xFFFFFFFF then 0.
  - Clear `ovf` in the same cycle as a drop: `ovf` remains 1.
